// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset front end.
// NOP / RESET_PC constants, opcode and funct values, and the {word, pc} issue entry
// buffered between instruction fetch and decode.
package mips_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Opcode and funct values. Where an opcode and a funct share an encoding they share a name.
  localparam logic [5:0] ADDI_JR = 6'h08;  // addi opcode / jr funct
  localparam logic [5:0] BLTZ    = 6'h01;  // REGIMM opcode, rt=0
  localparam logic [5:0] J       = 6'h02;  // j opcode
  localparam logic [5:0] LW_SUBU = 6'h23;  // lw opcode / subu funct
  localparam logic [5:0] NORR    = 6'h27;  // nor funct
  localparam logic [5:0] SLTU_SW = 6'h2b;  // sltu funct / sw opcode

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } issue_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Two-entry FIFO of issue entries ({word, pc}) sitting between fetch and decode.
// Ports: clk, rst_n (async, active-low), push/push_data, pop, flush (drops all entries),
//        head (oldest entry), full, empty.
module inst_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  issue_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output issue_entry_t head,
  output logic         full,
  output logic         empty
);

  issue_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/inst_issue.sv
// Instruction fetch/issue stage: fetches words from instruction memory (one request in
// flight), buffers them in a 2-entry FIFO and shifts them into a 3-deep history
// (instruction -> ex_inst -> mem_inst) that feeds the decoder and its forwarding logic.
// Ports: clk, rst_n (async, active-low); imem_req/imem_addr/imem_valid/imem_data memory
//        interface; stall, redirect, redirect_pc control; instruction, ex_inst, mem_inst,
//        issue_pc history outputs.
// Optional: define INST_ISSUE_BUBBLE_CNT_EN to add bubble_cnt, a saturating 16-bit count of
//           cycles in which a NOP enters instruction.
module inst_issue
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] ex_inst,
  output logic [31:0] mem_inst,
`ifdef INST_ISSUE_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic [31:0] issue_pc
);

  logic         active_q;  // holds imem_req low until the first edge after reset
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;  // address of the request in flight
  logic         pending_q;
  logic         discard_q; // in-flight response belongs to a flushed path
  logic [31:0]  instr_q;
  logic [31:0]  ex_q;
  logic [31:0]  mem_q;
  logic [31:0]  issue_pc_q;

  logic         resp_ret;
  logic         resp_ok;
  logic         advance;
  logic         take_head;
  logic         bypass;
  logic         fifo_push;
  logic         fifo_full;
  logic         fifo_empty;
  issue_entry_t fifo_head;
  issue_entry_t fifo_wdata;
  logic [1:0]   occ;
  logic [1:0]   occ_next;
  logic         req;

  // Responses with no matching request (e.g. after reset) are ignored via pending_q.
  assign resp_ret   = imem_valid && pending_q;
  assign resp_ok    = resp_ret && !discard_q && !redirect;
  assign advance    = !stall && !redirect;
  assign take_head  = advance && !fifo_empty;
  // With an empty FIFO an arriving word goes straight into decode.
  assign bypass     = advance && fifo_empty && resp_ok;
  assign fifo_push  = resp_ok && !bypass;
  assign fifo_wdata = '{word: imem_data, pc: req_pc_q};

  // A new request needs a FIFO slot left over after this cycle's push/pop.
  assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign occ_next = occ + 2'(fifo_push) - 2'(take_head);
  assign req      = active_q && !redirect && (!pending_q || resp_ret) && (occ_next < 2'd2);

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign ex_inst     = ex_q;
  assign mem_inst    = mem_q;
  assign issue_pc    = issue_pc_q;

  inst_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (take_head),
    .flush     (redirect),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      instr_q    <= NOP;
      ex_q       <= NOP;
      mem_q      <= NOP;
      issue_pc_q <= 32'h0;
    end else begin
      active_q <= 1'b1;

      if (req) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        req_pc_q   <= fetch_pc_q;
      end else if (redirect) begin
        fetch_pc_q <= redirect_pc;
      end

      if (req) begin
        pending_q <= 1'b1;
      end else if (resp_ret) begin
        pending_q <= 1'b0;
      end

      if (resp_ret) begin
        discard_q <= 1'b0;
      end else if (redirect && pending_q) begin
        discard_q <= 1'b1;
      end

      if (advance || redirect) begin
        mem_q <= ex_q;
        ex_q  <= instr_q;
        if (take_head) begin
          instr_q    <= fifo_head.word;
          issue_pc_q <= fifo_head.pc;
        end else if (bypass) begin
          instr_q    <= imem_data;
          issue_pc_q <= req_pc_q;
        end else begin
          instr_q <= NOP;
        end
      end
    end
  end

`ifdef INST_ISSUE_BUBBLE_CNT_EN
  logic nop_in;

  assign nop_in = (advance || redirect) && !take_head && !bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'h0;
    end else if (nop_in && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_issue.sv
// Bench for inst_issue: a latency-programmable memory model answers fetches; a negedge
// monitor pops expected fetch addresses and issued {word, pc} pairs from scoreboard queues.
module tb_inst_issue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] ex_inst;
  logic [31:0] mem_inst;
  logic [31:0] issue_pc;
`ifdef INST_ISSUE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  logic        mem_valid;
  logic [31:0] mem_data;
  logic        inj_valid;
  logic [31:0] inj_data;
  int          lat;
  int          cyc = 0;
  int          base = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] qa[$];
  int          qd[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_word[$];
  logic [31:0] exp_pc[$];
  logic [31:0] prev_ins;
  logic [31:0] prev_pc;

  localparam logic [31:0] WA = 32'h2001_0005;
  localparam logic [31:0] WB = 32'h2002_0003;
  localparam logic [31:0] WC = 32'h0022_1823;

  assign imem_valid = mem_valid | inj_valid;
  assign imem_data  = inj_valid ? inj_data : mem_data;

  inst_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .ex_inst     (ex_inst),
    .mem_inst    (mem_inst),
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    .bubble_cnt  (bubble_cnt),
`endif
    .issue_pc    (issue_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return WA;
      32'h4:   return WB;
      32'h8:   return WC;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Memory model: capture requests mid-cycle, answer lat cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qd.delete();
    end else if (imem_req) begin
      qa.push_back(imem_addr);
      qd.push_back(cyc + lat);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      qa.delete();
      qd.delete();
      mem_valid = 1'b0;
    end else if (qd.size() > 0 && qd[0] == cyc) begin
      mem_valid = 1'b1;
      mem_data  = mem_word(qa.pop_front());
      void'(qd.pop_front());
    end else begin
      mem_valid = 1'b0;
    end
  end

  // Monitor: every request and every newly issued word is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ins = 32'h0;
      prev_pc  = 32'h0;
    end else begin
      if (imem_req) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL imem_addr: got unexpected request %h, want none", imem_addr);
        end else begin
          chk32("imem_addr", imem_addr, exp_addr.pop_front());
        end
      end
      if (instruction != 32'h0 && (instruction != prev_ins || issue_pc != prev_pc)) begin
        if (exp_word.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL issue: got unexpected %h @ %h, want none", instruction, issue_pc);
        end else begin
          chk32("issue_word", instruction, exp_word.pop_front());
          chk32("issue_pc", issue_pc, exp_pc.pop_front());
        end
      end
      prev_ins = instruction;
      prev_pc  = issue_pc;
    end
  end

  task automatic to_pos(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_neg(input int k);
    to_pos(k);
    @(negedge clk);
  endtask

  task automatic assert_rst();
    rst_n     = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;
    inj_valid = 1'b0;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic push_issue(input logic [31:0] w, input logic [31:0] p);
    exp_word.push_back(w);
    exp_pc.push_back(p);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk32({tag, "_instruction"}, instruction, 32'h0);
    chk32({tag, "_ex_inst"}, ex_inst, 32'h0);
    chk32({tag, "_mem_inst"}, mem_inst, 32'h0);
    chk32({tag, "_issue_pc"}, issue_pc, 32'h0);
    chk32({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    chk32({tag, "_imem_addr"}, imem_addr, 32'h0);
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    chk32({tag, "_bubble_cnt"}, {16'h0, bubble_cnt}, 32'h0);
`endif
  endtask

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    inj_valid = 1'b0; inj_data = 32'h0; mem_valid = 1'b0; mem_data = 32'h0;
    lat = 1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");

    // Latency 1: back-to-back issue.
    lat = 1;
    foreach (exp_addr[i]) exp_addr.delete();
    for (int i = 0; i < 5; i++) exp_addr.push_back(32'(4 * i));
    push_issue(WA, 32'h0); push_issue(WB, 32'h4); push_issue(WC, 32'h8);
    release_rst();
    to_neg(0); chk32("s1_no_req_c0", {31'h0, imem_req}, 32'h0);
    to_neg(1); chk32("s1_first_req", {31'h0, imem_req}, 32'h1);
    to_neg(3); chk32("s1_instr_a", instruction, WA);
    to_neg(4); chk32("s1_instr_b", instruction, WB);
    to_neg(5); chk32("s1_instr_c", instruction, WC);
    chk32("s1_ex_b", ex_inst, WB);
    chk32("s1_mem_a", mem_inst, WA);
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    chk32("s1_bubbles", {16'h0, bubble_cnt}, 32'd2);
`endif
    #1; assert_rst();

    // Latency 3: two NOPs between issues.
    lat = 3;
    for (int i = 0; i < 4; i++) exp_addr.push_back(32'(4 * i));
    push_issue(WA, 32'h0); push_issue(WB, 32'h4); push_issue(WC, 32'h8);
    release_rst();
    to_neg(5); chk32("s2_instr_a", instruction, WA);
    to_neg(6); chk32("s2_bubble1", instruction, 32'h0);
    to_neg(7); chk32("s2_bubble2", instruction, 32'h0);
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    chk32("s2_bubbles_c7", {16'h0, bubble_cnt}, 32'd6);
`endif
    to_neg(8); chk32("s2_instr_b", instruction, WB);
    to_neg(11); chk32("s2_instr_c", instruction, WC);
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    chk32("s2_bubbles_c11", {16'h0, bubble_cnt}, 32'd8);
`endif
    #1; assert_rst();

    // Stall for 4 cycles while the FIFO fills.
    lat = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hc); exp_addr.push_back(32'h10); exp_addr.push_back(32'h14);
    push_issue(WA, 32'h0); push_issue(WB, 32'h4); push_issue(WC, 32'h8);
    release_rst();
    to_pos(3); stall = 1'b1;
    to_neg(4); chk32("s3_frozen_c4", instruction, WA);
    chk32("s3_no_req_c4", {31'h0, imem_req}, 32'h0);
    to_neg(5); chk32("s3_frozen_c5", instruction, WA);
    chk32("s3_fifo_full", {31'h0, dut.u_fifo.full}, 32'h1);
    chk32("s3_no_req_c5", {31'h0, imem_req}, 32'h0);
    to_neg(6); chk32("s3_pc_frozen", issue_pc, 32'h0);
    chk32("s3_ex_frozen", ex_inst, 32'h0);
    to_pos(7); stall = 1'b0;
    to_neg(7); chk32("s3_frozen_c7", instruction, WA);
    to_neg(8); chk32("s3_release_b", instruction, WB);
    to_neg(9); chk32("s3_release_c", instruction, WC);
    chk32("s3_mem_a", mem_inst, WA);
    #1; assert_rst();

    // Redirect while a request is outstanding.
    lat = 3;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h40); exp_addr.push_back(32'h44);
    push_issue(32'hA000_0040, 32'h40);
    release_rst();
    to_pos(2); redirect = 1'b1; redirect_pc = 32'h40;
    to_pos(3); redirect = 1'b0;
    to_neg(3); chk32("s4_nop_after_redirect", instruction, 32'h0);
    chk32("s4_no_req_pending", {31'h0, imem_req}, 32'h0);
    to_neg(4); chk32("s4_req_after_stale", {31'h0, imem_req}, 32'h1);
    to_neg(5); chk32("s4_stale_dropped", instruction, 32'h0);
    to_neg(8); chk32("s4_target_word", instruction, 32'hA000_0040);
    #1; assert_rst();

    // Reset pulsed mid-request, then a stray response after release.
    lat = 1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) exp_addr.push_back(32'(4 * i));
    push_issue(WA, 32'h0); push_issue(WA, 32'h0);
    release_rst();
    to_neg(3); chk32("s5_before_reset", instruction, WA);
    #2; assert_rst();
    #1; chk_zero_outputs("s5_async");
    inj_valid = 1'b1; inj_data = 32'hDEAD_BEEF;
    release_rst();
    to_neg(1); chk32("s5_first_req", {31'h0, imem_req}, 32'h1);
    to_pos(2); inj_valid = 1'b0;
    to_neg(2); chk32("s5_stray_ignored", instruction, 32'h0);
    to_neg(3); chk32("s5_instr_a", instruction, WA);
    #1; assert_rst();

    // Redirect and response in the same cycle, with stall high.
    lat = 1;
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h80);
    exp_addr.push_back(32'h84); exp_addr.push_back(32'h88);
    push_issue(WA, 32'h0); push_issue(32'hA000_0080, 32'h80);
    release_rst();
    to_pos(3); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    to_neg(3); chk32("s6_no_req_redirect", {31'h0, imem_req}, 32'h0);
    to_pos(4); stall = 1'b0; redirect = 1'b0;
    to_neg(4); chk32("s6_nop_shifted", instruction, 32'h0);
    chk32("s6_ex_a", ex_inst, WA);
    chk32("s6_pc_held", issue_pc, 32'h0);
    to_neg(5); chk32("s6_mem_a", mem_inst, WA);
    to_neg(6); chk32("s6_target", instruction, 32'hA000_0080);
    chk32("s6_ex_nop", ex_inst, 32'h0);
`ifdef INST_ISSUE_BUBBLE_CNT_EN
    chk32("s6_bubbles", {16'h0, bubble_cnt}, 32'd4);
`endif
    #1; assert_rst();

`ifdef INST_ISSUE_BUBBLE_CNT_EN
    // Memory never answers: every cycle is a bubble until the counter saturates.
    lat = 100000;
    exp_addr.push_back(32'h0);
    release_rst();
    to_neg(65534); chk32("sat_below", {16'h0, bubble_cnt}, 32'h0000_FFFE);
    to_neg(65540); chk32("sat_held", {16'h0, bubble_cnt}, 32'h0000_FFFF);
    #1; assert_rst();
`endif

    repeat (2) @(posedge clk);
    chk32("addr_queue_drained", 32'(exp_addr.size()), 32'h0);
    chk32("issue_queue_drained", 32'(exp_word.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
